// File: rtl/mac_mgnt_arbiter.sv
// rtl/mac_mgnt_arbiter.sv - round-robin arbiter sharing the MAC management bus across requesters.
// Optional build macro: MGNT_ARB_PRIO_EN (requester 0 gets strict priority).
module mac_mgnt_arbiter #(
    parameter int REQ_NUM  = 2,
    parameter int PORT_NUM = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rstn_sys,
    input  logic [REQ_NUM-1:0]    req_valid,
    input  logic [REQ_NUM-1:0]    req_wr,
    input  logic [4*REQ_NUM-1:0]  req_port,
    input  logic [8*REQ_NUM-1:0]  req_addr,
    input  logic [8*REQ_NUM-1:0]  req_data,
    output logic [REQ_NUM-1:0]    req_ack,
    output logic [7:0]            resp_data,
    output logic [REQ_NUM-1:0]    resp_valid,
    output logic                  resp_err,
    output logic [PORT_NUM-1:0]   sys_req_valid,
    output logic                  sys_req_wr,
    output logic [7:0]            sys_req_addr,
    input  logic [PORT_NUM-1:0]   sys_req_ack,
    output logic [7:0]            sys_req_data,
    output logic [PORT_NUM-1:0]   sys_req_data_valid,
    input  logic [8*PORT_NUM-1:0] sys_resp_data,
    input  logic [PORT_NUM-1:0]   sys_resp_data_valid,
    output logic                  busy
);

    localparam int OW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RWAIT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] TO_LIM   = 8'(TIMEOUT);
    localparam logic [4:0] PORT_LIM = 5'(PORT_NUM);

    logic [2:0]         state;
    logic [OW-1:0]      rr_ptr;
    logic [OW-1:0]      owner;
    logic               wr_q;
    logic [3:0]         port_q;
    logic [7:0]         addr_q;
    logic [7:0]         data_q;
    logic [7:0]         rdata_q;
    logic               err_q;
    logic [7:0]         to_cnt;

    logic [REQ_NUM-1:0] cand;
    int                 rr_idx;
    logic               pick_found;
    logic [OW-1:0]      pick_idx;
    logic               pick_wr;
    logic [3:0]         pick_port;
    logic [7:0]         pick_addr;
    logic [7:0]         pick_data;

    logic               port_ack;
    logic               port_rvalid;
    logic [7:0]         port_rdata;
    logic               timeout_hit;

    // Search starts at rr_ptr and wraps, so the last owner goes to the back of the line.
    always_comb begin
        cand       = req_valid;
`ifdef MGNT_ARB_PRIO_EN
        if (req_valid[0]) begin
            cand = REQ_NUM'(1);
        end
`endif
        rr_idx     = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_wr    = 1'b0;
        pick_port  = '0;
        pick_addr  = '0;
        pick_data  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            rr_idx = (int'(rr_ptr) + i) % REQ_NUM;
            if (!pick_found && cand[rr_idx]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(rr_idx);
                pick_wr    = req_wr[rr_idx];
                pick_port  = req_port[4*rr_idx +: 4];
                pick_addr  = req_addr[8*rr_idx +: 8];
                pick_data  = req_data[8*rr_idx +: 8];
            end
        end
    end

    always_comb begin
        port_ack    = 1'b0;
        port_rvalid = 1'b0;
        port_rdata  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (4'(p) == port_q) begin
                port_ack    = sys_req_ack[p];
                port_rvalid = sys_resp_data_valid[p];
                port_rdata  = sys_resp_data[8*p +: 8];
            end
        end
    end

    assign timeout_hit = (to_cnt == TO_LIM);

    // Request is withdrawn in the cycle the wait limit is reached.
    always_comb begin
        sys_req_valid      = '0;
        sys_req_data_valid = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (4'(p) == port_q) begin
                sys_req_valid[p]      = (state == ST_ISSUE) && !timeout_hit;
                sys_req_data_valid[p] = (state == ST_WDATA);
            end
        end
    end

    assign sys_req_wr   = wr_q;
    assign sys_req_addr = addr_q;
    assign sys_req_data = data_q;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wr_q       <= 1'b0;
            port_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            to_cnt     <= '0;
            req_ack    <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            req_ack    <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner             <= pick_idx;
                        wr_q              <= pick_wr;
                        port_q            <= pick_port;
                        addr_q            <= pick_addr;
                        data_q            <= pick_data;
                        rdata_q           <= '0;
                        to_cnt            <= '0;
                        req_ack[pick_idx] <= 1'b1;
                        if ({1'b0, pick_port} >= PORT_LIM) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (port_ack) begin
                        to_cnt <= '0;
                        state  <= wr_q ? ST_WDATA : ST_RWAIT;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_WDATA: begin
                    state <= ST_DONE;
                end
                ST_RWAIT: begin
                    if (port_rvalid) begin
                        rdata_q <= port_rdata;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    resp_valid[owner] <= 1'b1;
                    resp_err          <= err_q;
                    resp_data         <= (wr_q || err_q) ? 8'h00 : rdata_q;
                    rr_ptr            <= (owner == OW'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
                    state             <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
